// File: rtl/wt_loader_if.sv
// Weight-path bundle for wt_loader: FIFO read port toward the weight FIFO and
// the row-load strobe toward the systolic array.
interface wt_loader_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ROWS       = 3
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_empty;
    logic                  wt_load_en;
    logic [ROW_W-1:0]      wt_row_sel;
    logic [DATA_WIDTH-1:0] wt_data;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_rd_empty,
        output wt_load_en,
        output wt_row_sel,
        output wt_data
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_rd_empty,
        input  wt_load_en,
        input  wt_row_sel,
        input  wt_data
    );
endinterface

// File: rtl/wt_loader.sv
// Streams num_tiles*ROWS packed weight words from a FIFO into systolic array
// rows, one row per word, with stall on empty, abort, and a done pulse.
module wt_loader #(
    parameter int DATA_WIDTH = 24,
    parameter int WT_WIDTH   = 8,
    parameter int ROWS       = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  num_tiles,
    input  logic        abort,
    wt_loader_if.master bus,
    output logic        busy,
    output logic        done,
    output logic [7:0]  tile_cnt
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W = 10;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      total_q, total_d;
    logic [CNT_W-1:0]      issued_q, issued_d;
    logic [CNT_W-1:0]      loaded_q, loaded_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [7:0]            tile_cnt_q, tile_cnt_d;
    logic                  vld_q, vld_d;
    logic                  wt_load_en_q, wt_load_en_d;
    logic [ROW_W-1:0]      wt_row_sel_q, wt_row_sel_d;
    logic [DATA_WIDTH-1:0] wt_data_q, wt_data_d;
    logic                  kill;
    logic                  pop;

    // Abort only matters while a load is active; it also gates this cycle's pop.
    always_comb begin
        kill = abort && ((state_q == RUN) || (state_q == DRAIN));
        pop  = (state_q == RUN) && !bus.fifo_rd_empty && (issued_q < total_q) && !kill;
    end

    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        issued_d     = issued_q;
        loaded_d     = loaded_q;
        row_d        = row_q;
        tile_cnt_d   = tile_cnt_q;
        vld_d        = pop;
        wt_load_en_d = 1'b0;
        wt_row_sel_d = wt_row_sel_q;
        wt_data_d    = wt_data_q;

        if (pop) begin
            issued_d = issued_q + 1'b1;
        end

        // FIFO data is valid the cycle after the pop; capture it unless aborted.
        if (vld_q && !kill) begin
            wt_load_en_d = 1'b1;
            wt_row_sel_d = row_q;
            wt_data_d    = '0;
            for (int unsigned i = 0; i < ROWS; i++) begin
                wt_data_d[i*WT_WIDTH +: WT_WIDTH] = bus.fifo_rd_data[i*WT_WIDTH +: WT_WIDTH];
            end
            loaded_d = loaded_q + 1'b1;
            if (row_q == LAST_ROW) begin
                row_d = '0;
                if (tile_cnt_q != '1) begin
                    tile_cnt_d = tile_cnt_q + 1'b1;
                end
            end else begin
                row_d = row_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    total_d    = CNT_W'(num_tiles) * CNT_W'(ROWS);
                    issued_d   = '0;
                    loaded_d   = '0;
                    row_d      = '0;
                    tile_cnt_d = '0;
                    state_d    = (num_tiles == 8'd0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (issued_q == total_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (loaded_q == total_q) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            total_q      <= '0;
            issued_q     <= '0;
            loaded_q     <= '0;
            row_q        <= '0;
            tile_cnt_q   <= '0;
            vld_q        <= 1'b0;
            wt_load_en_q <= 1'b0;
            wt_row_sel_q <= '0;
            wt_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            issued_q     <= issued_d;
            loaded_q     <= loaded_d;
            row_q        <= row_d;
            tile_cnt_q   <= tile_cnt_d;
            vld_q        <= vld_d;
            wt_load_en_q <= wt_load_en_d;
            wt_row_sel_q <= wt_row_sel_d;
            wt_data_q    <= wt_data_d;
        end
    end

    assign bus.fifo_rd_en = pop;
    assign bus.wt_load_en = wt_load_en_q;
    assign bus.wt_row_sel = wt_row_sel_q;
    assign bus.wt_data    = wt_data_q;
    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == FIN);
    assign tile_cnt       = tile_cnt_q;
endmodule

// File: tb/tb_wt_loader.sv
// Scoreboard bench for wt_loader: directed loads, stalls, abort, reset and a
// full 255-tile run, checked by a negedge monitor against queued expectations.
module tb_wt_loader;
    typedef struct packed {
        logic [1:0]  row;
        logic [23:0] data;
    } exp_t;

    localparam logic [23:0] W [6] = '{24'h112233, 24'h445566, 24'h778899,
                                      24'hAABBCC, 24'hDDEEFF, 24'h0F1E2D};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] num_tiles = 8'd0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] tile_cnt;

    logic        hold_empty = 1'b0;
    logic [23:0] word_mem [1024];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          cyc = 0;

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   load_cyc[$];
    int   done_cyc[$];
    int   n_loads = 0;
    int   tests = 0;
    int   failures = 0;

    wt_loader_if #(.DATA_WIDTH(24), .ROWS(3)) bus ();

    wt_loader #(.DATA_WIDTH(24), .WT_WIDTH(8), .ROWS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_tiles (num_tiles),
        .abort     (abort),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .tile_cnt  (tile_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // FIFO model: read data appears the cycle after fifo_rd_en.
    assign bus.fifo_rd_empty = (rd_ptr == wr_ptr) || hold_empty;
    always @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= 0;
        end else if (bus.fifo_rd_en) begin
            bus.fifo_rd_data <= word_mem[rd_ptr[9:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.fifo_rd_en) begin
                pop_cyc.push_back(cyc);
                chk("pop_not_empty", 32'(bus.fifo_rd_empty), 32'd0);
            end
            if (bus.wt_load_en) begin
                load_cyc.push_back(cyc);
                n_loads++;
                if (exp_q.size() == 0) begin
                    tests++;
                    failures++;
                    $display("FAIL unexpected_load: row %0d data 0x%0h, none expected", bus.wt_row_sel, bus.wt_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("load_row", 32'(bus.wt_row_sel), 32'(e.row));
                    chk("load_data", 32'(bus.wt_data), 32'(e.data));
                end
            end
            if (done) begin
                done_cyc.push_back(cyc);
                chk("busy_low_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic fifo_push(input logic [23:0] d);
        word_mem[wr_ptr[9:0]] = d;
        wr_ptr++;
    endtask

    task automatic push_exp(input logic [1:0] row, input logic [23:0] d);
        exp_t e;
        e.row  = row;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_fifo_rd_en"}, 32'(bus.fifo_rd_en), 32'd0);
        chk({tag, "_wt_load_en"}, 32'(bus.wt_load_en), 32'd0);
        chk({tag, "_wt_row_sel"}, 32'(bus.wt_row_sel), 32'd0);
        chk({tag, "_wt_data"}, 32'(bus.wt_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_tile_cnt"}, 32'(tile_cnt), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        hold_empty = 1'b0;
        wr_ptr = 0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        pop_cyc.delete();
        load_cyc.delete();
        done_cyc.delete();
        n_loads = 0;
        rst_n = 1'b1;
    endtask

    task automatic do_start(input logic [7:0] n);
        @(posedge clk);
        #1;
        start = 1'b1;
        num_tiles = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (n == 8'd0) chk("done_next_cycle", 32'(done), 32'd1);
        else chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    function automatic int count_of(input int which);
        case (which)
            0: return pop_cyc.size();
            1: return n_loads;
            default: return done_cyc.size();
        endcase
    endfunction

    // Bounded wait; a timeout shows up as a count mismatch.
    task automatic wait_for(input string name, input int which, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (count_of(which) >= target) break;
        end
        chk(name, 32'(count_of(which)), 32'(target));
    endtask

    initial begin
        int refill_cyc;

        // Two full tiles, FIFO pre-filled: back-to-back pops and loads.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fifo_push(W[i]);
            push_exp(2'(i % 3), W[i]);
        end
        do_start(8'd2);
        wait_for("t1_done", 2, 1, 50);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_pops", 32'(pop_cyc.size()), 32'd6);
        chk("t1_pops_consecutive", 32'(pop_cyc[5] - pop_cyc[0]), 32'd5);
        chk("t1_first_load_lat", 32'(load_cyc[0] - pop_cyc[0]), 32'd2);
        chk("t1_last_load_lat", 32'(load_cyc[5] - pop_cyc[0]), 32'd7);
        chk("t1_done_after_load", 32'(done_cyc[0] - load_cyc[5]), 32'd1);
        chk("t1_done_count", 32'(done_cyc.size()), 32'd1);
        chk("t1_tile_cnt", 32'(tile_cnt), 32'd2);
        chk("t1_exp_drained", 32'(exp_q.size()), 32'd0);

        // Zero tiles: done next cycle, FIFO untouched.
        do_reset();
        fifo_push(W[0]);
        fifo_push(W[1]);
        fifo_push(W[2]);
        do_start(8'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("t2_no_pops", 32'(pop_cyc.size()), 32'd0);
        chk("t2_done_count", 32'(done_cyc.size()), 32'd1);
        chk("t2_tile_cnt", 32'(tile_cnt), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);

        // Empty stall mid-tile after two pops.
        do_reset();
        fifo_push(W[0]);
        fifo_push(W[1]);
        push_exp(2'd0, W[0]);
        push_exp(2'd1, W[1]);
        push_exp(2'd2, W[2]);
        do_start(8'd1);
        wait_for("t3_two_pops", 0, 2, 20);
        @(posedge clk);
        #1;
        hold_empty = 1'b1;
        fifo_push(W[2]);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_no_pop_while_empty", 32'(pop_cyc.size()), 32'd2);
        chk("t3_still_busy", 32'(busy), 32'd1);
        hold_empty = 1'b0;
        refill_cyc = cyc;
        wait_for("t3_done", 2, 1, 30);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_loads", 32'(n_loads), 32'd3);
        chk("t3_done_once", 32'(done_cyc.size()), 32'd1);
        chk("t3_row2_after_refill", 32'((load_cyc.size() == 3) && (load_cyc[2] > refill_cyc)), 32'd1);
        chk("t3_tile_cnt", 32'(tile_cnt), 32'd1);

        // Abort one cycle after the first pop, then a fresh one-tile load.
        do_reset();
        for (int i = 0; i < 6; i++) fifo_push(W[i]);
        do_start(8'd2);
        wait_for("t4_first_pop", 0, 1, 20);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("t4_busy_after_abort", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_single_pop", 32'(pop_cyc.size()), 32'd1);
        chk("t4_no_loads", 32'(n_loads), 32'd0);
        chk("t4_no_done", 32'(done_cyc.size()), 32'd0);
        chk("t4_tile_cnt_held", 32'(tile_cnt), 32'd0);
        push_exp(2'd0, W[1]);
        push_exp(2'd1, W[2]);
        push_exp(2'd2, W[3]);
        do_start(8'd1);
        wait_for("t4_restart_done", 2, 1, 30);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_restart_loads", 32'(n_loads), 32'd3);
        chk("t4_restart_tile_cnt", 32'(tile_cnt), 32'd1);

        // Extra start while busy is ignored; async reset mid-load kills in-flight data.
        do_reset();
        for (int i = 0; i < 6; i++) fifo_push(W[i]);
        for (int i = 0; i < 4; i++) push_exp(2'(i % 3), W[i]);
        do_start(8'd2);
        @(posedge clk);
        #1;
        start = 1'b1;
        num_tiles = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_for("t5_four_loads", 1, 4, 20);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t5_async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_load_after_reset", 32'(bus.wt_load_en), 32'd0);
        end
        chk("t5_loads", 32'(n_loads), 32'd4);
        chk("t5_no_done", 32'(done_cyc.size()), 32'd0);
        chk("t5_exp_drained", 32'(exp_q.size()), 32'd0);

        // Maximum tile count with a FIFO that never runs dry.
        do_reset();
        for (int i = 0; i < 765; i++) begin
            fifo_push(24'(i * 7 + 24'h100003));
            push_exp(2'(i % 3), 24'(i * 7 + 24'h100003));
        end
        do_start(8'd255);
        wait_for("t6_done", 2, 1, 1000);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_loads", 32'(n_loads), 32'd765);
        chk("t6_tile_cnt", 32'(tile_cnt), 32'd255);
        chk("t6_done_once", 32'(done_cyc.size()), 32'd1);
        chk("t6_exp_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wt_loader.md
WT_LOADER -- requirements
Module: wt_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, meaning width of one FIFO word (ROWS packed weights).
REQ-002 SHALL have parameter WT_WIDTH, default 8, meaning width of one weight.
REQ-003 SHALL have parameter ROWS, default 3, meaning systolic array rows, i.e. FIFO words per tile.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a weight load.
REQ-007 SHALL have port num_tiles  input  8  tiles to load, sampled when start is accepted.
REQ-008 SHALL have port abort  input  1  synchronous cancel of an active load.
REQ-009 SHALL have port fifo_rd_en  output  1  pop request to the weight FIFO.
REQ-010 SHALL have port fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
REQ-011 SHALL have port fifo_rd_empty  input  1  FIFO empty flag.
REQ-012 SHALL have port wt_load_en  output  1  strobe: wt_data is written into row wt_row_sel.
REQ-013 SHALL have port wt_row_sel  output  $clog2(ROWS)  target array row.
REQ-014 SHALL have port wt_data  output  DATA_WIDTH  ROWS weights; weight i in bits [i*WT_WIDTH +: WT_WIDTH] goes to column i.
REQ-015 SHALL have port busy  output  1  high from start acceptance until done.
REQ-016 SHALL have port done  output  1  one-cycle pulse at load completion.
REQ-017 SHALL have port tile_cnt  output  8  tiles fully loaded in current/last operation.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN, FIN.
REQ-019 SHALL, in IDLE, accept start: latch total = num_tiles*ROWS (10-bit, no overflow), clear issued/loaded/row/tile counters, go to RUN (busy=1 next cycle).
REQ-020 SHALL, for start with num_tiles==0, go directly to FIN, issue no pops, and pulse done with tile_cnt=0.
REQ-021 SHALL ignore start when not in IDLE.
REQ-022 SHALL drive fifo_rd_en combinationally = (state==RUN) && !fifo_rd_empty && issued<total; never pop when empty.
REQ-023 SHALL register a valid bit one cycle after each pop and, when set, register wt_data<=fifo_rd_data, wt_load_en<=1, wt_row_sel<=row: pop at cycle t -> wt_load_en at t+2.
REQ-024 SHALL advance row 0..ROWS-1 on each load, wrapping to 0 and incrementing tile_cnt on wrap (tile_cnt saturates at 255).
REQ-025 SHALL, when issued reaches total, go RUN->DRAIN; DRAIN->FIN when loaded==total.
REQ-026 SHALL, in FIN, pulse done=1 and busy=0 in the same cycle for one cycle, then return to IDLE.
REQ-027 SHALL stall on fifo_rd_empty without error; already-issued reads still complete and load.
REQ-028 SHALL, on abort in RUN or DRAIN, stop popping immediately, suppress all further wt_load_en (including in-flight reads), go to IDLE without done; tile_cnt holds value.
REQ-029 SHALL permit a new start in the cycle after done (back-to-back loads).

Reset
REQ-030 SHALL, on rst_n low, asynchronously force IDLE and busy=0, done=0, wt_load_en=0, wt_row_sel=0, wt_data=0, tile_cnt=0, all counters and valid bit 0; fifo_rd_en=0 follows.
REQ-031 SHALL, on reset mid-load, discard in-flight data; first post-reset cycle shows no wt_load_en.

Verification
REQ-032 SHALL verify: FIFO holds 6 words, start num_tiles=2 -> 6 pops in 6 consecutive cycles, wt_load_en on cycles t+2..t+7 with wt_row_sel 0,1,2,0,1,2, data in pop order, done one cycle after last load, tile_cnt=2.
REQ-033 SHALL verify: start num_tiles=0 -> no fifo_rd_en, done pulse next cycle, tile_cnt=0.
REQ-034 SHALL verify: fifo_rd_empty high 5 cycles mid-tile (after 2 pops, num_tiles=1) -> no pops while empty, row 2 loads after refill, done once, exactly 3 loads total.
REQ-035 SHALL verify: abort one cycle after a pop, num_tiles=2 -> that popped word not loaded, no done, busy=0 next cycle, subsequent start works normally.
REQ-036 SHALL verify: start asserted while busy and rst_n asserted mid-load -> extra start ignored; reset clears all outputs to 0 asynchronously with no load strobe afterwards.
REQ-037 SHALL verify: start num_tiles=255 with FIFO never empty -> 765 loads, tile_cnt=255, done exactly once.
